// File: rtl/sdram_frame_swap_ctrl.sv
// rtl/sdram_frame_swap_ctrl.sv - triple-buffer frame manager driving one write and one read SDRAM port
module sdram_frame_swap_ctrl #(
   parameter int               ASIZE       = 23,
   parameter logic [ASIZE-1:0] BASE0       = 23'h000000,
   parameter logic [ASIZE-1:0] BASE1       = 23'h100000,
   parameter logic [ASIZE-1:0] BASE2       = 23'h200000,
   parameter int               FRAME_WORDS = 307200,
   parameter int               BURST_LEN   = 256,
   parameter int               LOAD_CYCLES = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             ENABLE,
   input  logic             WR_VSYNC,
   input  logic             RD_VSYNC,
   output logic [ASIZE-1:0] WR_ADDR,
   output logic [ASIZE-1:0] WR_MAX_ADDR,
   output logic [8:0]       WR_LENGTH,
   output logic             WR_LOAD,
   output logic [ASIZE-1:0] RD_ADDR,
   output logic [ASIZE-1:0] RD_MAX_ADDR,
   output logic [8:0]       RD_LENGTH,
   output logic             RD_LOAD,
   output logic [1:0]       WR_BUF,
   output logic [1:0]       RD_BUF,
   output logic             FRAME_DROP,
   output logic             FRAME_REPEAT,
   output logic             OVERRUN
);

   localparam int               CW       = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
   localparam logic [CW-1:0]    CNT_INIT = CW'(LOAD_CYCLES - 1);
   localparam logic [ASIZE-1:0] FW       = ASIZE'(FRAME_WORDS);

   typedef enum logic [2:0] {CH_RST, CH_INIT, CH_IDLE, CH_LOAD, CH_GAP} ch_state_t;

   ch_state_t     wr_st, rd_st;
   logic [CW-1:0] wr_cnt, rd_cnt;
   logic          wr_vs_s, wr_vs_p, wr_evt;
   logic          rd_vs_s, rd_vs_p, rd_evt;
   logic          wr_pend, rd_pend;
   logic [1:0]    l_buf;
   logic          fresh, primed;

   logic          wr_go, rd_go, commit;
   logic [1:0]    l_nxt, r_nxt, w_nxt;
   logic          fresh_w, fresh_nxt, primed_nxt;
   logic          drop_nxt, rep_nxt;
   logic          wr_pend_nxt, rd_pend_nxt, wr_ovr, rd_ovr;

   assign WR_LENGTH = 9'(BURST_LEN);
   assign RD_LENGTH = 9'(BURST_LEN);

   function automatic logic [ASIZE-1:0] base_of(input logic [1:0] idx);
      case (idx)
         2'd0:    base_of = BASE0;
         2'd1:    base_of = BASE1;
         default: base_of = BASE2;
      endcase
   endfunction

   // A pending event left in GAP restarts the load immediately, so LOAD drops for only one cycle.
   always_comb begin
      wr_go = ((wr_st == CH_IDLE) && (wr_evt || wr_pend)) || ((wr_st == CH_GAP) && wr_pend);
      rd_go = ((rd_st == CH_IDLE) && (rd_evt || rd_pend)) || ((rd_st == CH_GAP) && rd_pend);

      wr_pend_nxt = wr_go ? (wr_pend && wr_evt) : (wr_pend || wr_evt);
      rd_pend_nxt = rd_go ? (rd_pend && rd_evt) : (rd_pend || rd_evt);
      wr_ovr      = !wr_go && wr_evt && wr_pend;
      rd_ovr      = !rd_go && rd_evt && rd_pend;

      // Write bookkeeping first; the read then sees the committed frame.
      commit     = wr_go && primed;
      l_nxt      = commit ? WR_BUF : l_buf;
      fresh_w    = commit ? 1'b1 : fresh;
      primed_nxt = primed || wr_go;
      drop_nxt   = commit && fresh && !rd_go;

      r_nxt     = RD_BUF;
      fresh_nxt = fresh_w;
      rep_nxt   = 1'b0;
      if (rd_go) begin
         if (fresh_w) begin
            r_nxt     = l_nxt;
            fresh_nxt = 1'b0;
         end else begin
            rep_nxt = 1'b1;
         end
      end

      if (r_nxt != 2'd0 && l_nxt != 2'd0)
         w_nxt = 2'd0;
      else if (r_nxt != 2'd1 && l_nxt != 2'd1)
         w_nxt = 2'd1;
      else
         w_nxt = 2'd2;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_st        <= CH_RST;
         rd_st        <= CH_RST;
         wr_cnt       <= '0;
         rd_cnt       <= '0;
         wr_vs_s      <= 1'b0;
         wr_vs_p      <= 1'b0;
         wr_evt       <= 1'b0;
         rd_vs_s      <= 1'b0;
         rd_vs_p      <= 1'b0;
         rd_evt       <= 1'b0;
         wr_pend      <= 1'b0;
         rd_pend      <= 1'b0;
         l_buf        <= 2'd2;
         fresh        <= 1'b0;
         primed       <= 1'b0;
         WR_BUF       <= 2'd0;
         RD_BUF       <= 2'd2;
         WR_ADDR      <= BASE0;
         WR_MAX_ADDR  <= BASE0 + FW;
         RD_ADDR      <= BASE2;
         RD_MAX_ADDR  <= BASE2 + FW;
         WR_LOAD      <= 1'b0;
         RD_LOAD      <= 1'b0;
         FRAME_DROP   <= 1'b0;
         FRAME_REPEAT <= 1'b0;
         OVERRUN      <= 1'b0;
      end else begin
         wr_vs_s <= WR_VSYNC;
         wr_vs_p <= wr_vs_s;
         wr_evt  <= wr_vs_s && !wr_vs_p && ENABLE;
         rd_vs_s <= RD_VSYNC;
         rd_vs_p <= rd_vs_s;
         rd_evt  <= rd_vs_s && !rd_vs_p && ENABLE;

         wr_pend      <= wr_pend_nxt;
         rd_pend      <= rd_pend_nxt;
         l_buf        <= l_nxt;
         fresh        <= fresh_nxt;
         primed       <= primed_nxt;
         FRAME_DROP   <= drop_nxt;
         FRAME_REPEAT <= rep_nxt;
         OVERRUN      <= wr_ovr || rd_ovr;

         case (wr_st)
            CH_RST: begin
               WR_LOAD <= 1'b1;
               wr_cnt  <= CNT_INIT;
               wr_st   <= CH_INIT;
            end
            CH_INIT, CH_LOAD: begin
               if (wr_cnt == '0) begin
                  WR_LOAD <= 1'b0;
                  wr_st   <= (wr_st == CH_INIT) ? CH_IDLE : CH_GAP;
               end else begin
                  wr_cnt <= wr_cnt - CW'(1);
               end
            end
            CH_GAP:  wr_st <= CH_IDLE;
            default: wr_st <= CH_IDLE;
         endcase

         case (rd_st)
            CH_RST: begin
               RD_LOAD <= 1'b1;
               rd_cnt  <= CNT_INIT;
               rd_st   <= CH_INIT;
            end
            CH_INIT, CH_LOAD: begin
               if (rd_cnt == '0) begin
                  RD_LOAD <= 1'b0;
                  rd_st   <= (rd_st == CH_INIT) ? CH_IDLE : CH_GAP;
               end else begin
                  rd_cnt <= rd_cnt - CW'(1);
               end
            end
            CH_GAP:  rd_st <= CH_IDLE;
            default: rd_st <= CH_IDLE;
         endcase

         if (wr_go) begin
            WR_LOAD     <= 1'b1;
            wr_cnt      <= CNT_INIT;
            wr_st       <= CH_LOAD;
            WR_BUF      <= w_nxt;
            WR_ADDR     <= base_of(w_nxt);
            WR_MAX_ADDR <= base_of(w_nxt) + FW;
         end
         if (rd_go) begin
            RD_LOAD     <= 1'b1;
            rd_cnt      <= CNT_INIT;
            rd_st       <= CH_LOAD;
            RD_BUF      <= r_nxt;
            RD_ADDR     <= base_of(r_nxt);
            RD_MAX_ADDR <= base_of(r_nxt) + FW;
         end
      end
   end

endmodule
